// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/full_adder_using_mux.sv
// One-bit full adder built only from 2:1 multiplexers; shared by every bit slot.
module full_adder_using_mux (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic prop;

  // a ^ b expressed as a mux selected by b.
  assign prop = b ? ~a : a;
  assign sum  = cin ? ~prop : prop;
  assign cout = prop ? cin : a;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one shared full-adder cell, LSB first,
// WIDTH processing edges per operation followed by a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  assign last_bit = (cnt == LAST);

  full_adder_using_mux u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Handshake: start is accepted on any edge where the FSM is not in RUN
  // (IDLE or DONE); it is dropped, not queued, while busy. done is a
  // one-cycle strobe marking sum/cout valid; they then hold until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_cout;
          sum   <= {fa_sum, sum[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            state_q <= ST_DONE;
            cout    <= fa_cout;
          end
        end
        default: begin
          if (start) begin
            state_q <= ST_RUN;
            a_sr    <= a;
            // Subtraction is A + ~B + 1; the caller's cin is irrelevant then.
            b_sr    <= sub ? ~b : b;
            carry   <= sub ? 1'b1 : cin;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign state = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: arithmetic reference model plus
// directed literal cases, busy protection, back-to-back, async reset and random traffic.
module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Reference model: arithmetic result computed whole at accept time; the
  // operation then occupies W edges, one bit of the result appearing per edge.
  logic         m_run;
  int           m_k;
  logic [W:0]   m_res;
  logic         m_done;
  logic [W-1:0] m_hold_sum;
  logic         m_hold_cout;

  function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c, input logic s);
    longint mask;
    longint r;
    mask = (longint'(1) << W) - 1;
    if (s) r = longint'(x) + (mask - longint'(y)) + 1;
    else   r = longint'(x) + longint'(y) + longint'(c);
    return r[W:0];
  endfunction

  function automatic logic [W-1:0] partial_sum(input logic [W:0] res, input int k);
    longint low;
    low = longint'(res[W-1:0]) & ((longint'(1) << k) - 1);
    return W'(low << (W - k));
  endfunction

  initial begin
    m_run = 0; m_k = 0; m_res = '0; m_done = 0; m_hold_sum = '0; m_hold_cout = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_k = 0; m_done = 0; m_hold_sum = '0; m_hold_cout = 0;
      end else if (m_run) begin
        m_k++;
        if (m_k == W) begin
          m_run = 0;
          m_done = 1;
          m_hold_sum = m_res[W-1:0];
          m_hold_cout = m_res[W];
        end
      end else begin
        m_done = 0;
        if (start) begin
          m_run = 1;
          m_k = 0;
          m_res = ref_result(a, b, cin, sub);
          m_hold_sum = '0;
          m_hold_cout = 0;
        end
      end
    end
  end

  // Scoreboard compare, every cycle, away from the active edge.
  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_run));
    check("done", 64'(done), 64'(m_done));
    check("sum", 64'(sum), m_run ? 64'(partial_sum(m_res, m_k)) : 64'(m_hold_sum));
    if (!m_run) check("cout", 64'(cout), 64'(m_hold_cout));
  end

  // Driver tasks
  task automatic idle_inputs();
    start = 0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Issue one operation from IDLE/DONE and check literal result and timing.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic tsub, input logic [W-1:0] es, input logic ec, input string nm);
    int cyc;
    int busy_cnt;
    bit seen;
    @(posedge clk); #1;
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1;
    @(posedge clk); #1;
    idle_inputs();
    cyc = 0; busy_cnt = 0; seen = 0;
    while (!seen && cyc <= W + 4) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) seen = 1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    check({nm, "_done_seen"}, 64'(seen), 64'(1));
    check({nm, "_latency"}, 64'(cyc), 64'(W));
    check({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({nm, "_sum"}, 64'(sum), 64'(es));
    check({nm, "_cout"}, 64'(cout), 64'(ec));
  endtask

  initial begin
    int done_cnt;
    int last_done;
    int cyc;
    logic [W-1:0] sv_sum;

    rst_n = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1;

    // Directed cases with hand-computed results.
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "add_5a_3c");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "wrap_ff_01");
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, "wrap_ff_cin");
    run_op(8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, "sub_10_01");
    run_op(8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, "sub_00_01");
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub_10_01_c0");

    // Busy protection: new starts in RUN cycles 2 and 5 are dropped.
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; cin = 0; sub = 0; start = 1;
    @(posedge clk); #1;
    idle_inputs();
    done_cnt = 0; sv_sum = '0;
    for (int i = 1; i <= W + 6; i++) begin
      if (i == 2 || i == 5) begin
        a = 8'hEE; b = 8'h77; cin = 1; sub = 1; start = 1;
      end
      @(negedge clk);
      if (done) begin
        done_cnt++;
        sv_sum = sum;
      end
      @(posedge clk); #1;
      start = 0;
    end
    check("busy_prot_done_count", 64'(done_cnt), 64'(1));
    check("busy_prot_sum", 64'(sv_sum), 64'(8'h46));

    // Back-to-back: start held high, fresh operands every cycle.
    start = 1;
    done_cnt = 0; last_done = -1; cyc = 0;
    repeat (5 * (W + 1) + 2) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
      if (done) begin
        if (last_done >= 0) check("b2b_interval", 64'(cyc - last_done), 64'(W + 1));
        last_done = cyc;
        done_cnt++;
      end
      cyc++;
    end
    check("b2b_done_count", 64'(done_cnt >= 4), 64'(1));
    @(posedge clk); #1;
    idle_inputs();
    repeat (W + 3) @(posedge clk);

    // Asynchronous reset in RUN cycle 4.
    @(posedge clk); #1;
    a = 8'hA5; b = 8'h5A; cin = 1; sub = 0; start = 1;
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_done", 64'(done), 64'(0));
    check("async_rst_sum", 64'(sum), 64'(0));
    check("async_rst_cout", 64'(cout), 64'(0));
    check("async_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1;
    done_cnt = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("async_rst_no_done", 64'(done_cnt), 64'(0));
    run_op(8'h81, 8'h7F, 1'b0, 1'b0, 8'h00, 1'b1, "after_rst");

    // Random traffic, including starts fired while busy.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    end
    @(posedge clk); #1;
    idle_inputs();
    repeat (W + 3) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
